// File: rtl/bola_if.sv
`default_nettype none
// ============================================================================
// Module  : bola_if
// Brief   : Paddle-to-ball bus: paddle positions/smash speeds, serve button,
//           ball position, direction and goal flags.
// Revision: 1.0
// ============================================================================
interface bola_if;
  logic [9:0] x_barra1;
  logic [9:0] y_barra1;
  logic [9:0] vel_porradao1;
  logic [9:0] x_barra2;
  logic [9:0] y_barra2;
  logic [9:0] vel_porradao2;
  logic       saque;
  logic [9:0] x_bola;
  logic [9:0] y_bola;
  logic       dir_x;
  logic       dir_y;
  logic       em_jogo;
  logic       gol_esq;
  logic       gol_dir;

  modport master (
    output x_barra1, y_barra1, vel_porradao1,
    output x_barra2, y_barra2, vel_porradao2,
    output saque,
    input  x_bola, y_bola, dir_x, dir_y, em_jogo, gol_esq, gol_dir
  );

  modport slave (
    input  x_barra1, y_barra1, vel_porradao1,
    input  x_barra2, y_barra2, vel_porradao2,
    input  saque,
    output x_bola, y_bola, dir_x, dir_y, em_jogo, gol_esq, gol_dir
  );
endinterface
`default_nettype wire

// File: rtl/bola.sv
`default_nettype none
// ============================================================================
// Module  : bola
// Brief   : Ball engine: moves the ball, bounces off walls and paddles,
//           reports goals and re-centres after a goal pause.
// Revision: 1.0
// ============================================================================
module bola #(
  parameter int X_INICIAL       = 318,
  parameter int Y_INICIAL       = 238,
  parameter int TAMANHO_BOLA    = 4,
  parameter int LARGURA_BARRA   = 20,
  parameter int ALTURA_BARRA    = 60,
  parameter int LIMITE_ESQ      = 0,
  parameter int LIMITE_DIR      = 640,
  parameter int LIMITE_CIMA     = 0,
  parameter int LIMITE_BAIXO    = 480,
  parameter int VELOCIDADE_BASE = 10,
  parameter int LIMIAR          = 2500000,
  parameter int TEMPO_GOL       = 50000000
) (
  input  logic  clk,
  input  logic  reset,
  bola_if.slave bus
);

  typedef enum logic [1:0] {
    PARADA = 2'd0,
    JOGO   = 2'd1,
    GOL    = 2'd2
  } estado_t;

  localparam logic [9:0]  c_x_ini     = 10'(X_INICIAL);
  localparam logic [9:0]  c_y_ini     = 10'(Y_INICIAL);
  localparam logic [11:0] c_tam       = 12'(TAMANHO_BOLA);
  localparam logic [11:0] c_larg      = 12'(LARGURA_BARRA);
  localparam logic [11:0] c_alt       = 12'(ALTURA_BARRA);
  localparam logic [11:0] c_lim_esq   = 12'(LIMITE_ESQ);
  localparam logic [11:0] c_lim_dir   = 12'(LIMITE_DIR);
  localparam logic [11:0] c_lim_cima  = 12'(LIMITE_CIMA);
  localparam logic [11:0] c_lim_baixo = 12'(LIMITE_BAIXO);
  localparam logic [31:0] c_vel_base  = 32'(VELOCIDADE_BASE);
  localparam logic [31:0] c_limiar    = 32'(LIMIAR);
  localparam logic [31:0] c_tempo_gol = 32'(TEMPO_GOL);

  estado_t     estado_q;
  logic [9:0]  x_bola_q;
  logic [9:0]  y_bola_q;
  logic        dir_x_q;
  logic        dir_y_q;
  logic        em_jogo_q;
  logic        gol_esq_q;
  logic        gol_dir_q;
  logic [31:0] cont_h_q;
  logic [31:0] cont_v_q;
  logic [31:0] cont_gol_q;
  logic [9:0]  bonus_q;

  logic [11:0] w_bx;
  logic [11:0] w_by;
  logic [11:0] w_bx_fim;
  logic [11:0] w_by_fim;
  logic [10:0] w_vel_h;
  logic        w_dir_y_nova;
  logic        w_gol_esq;
  logic        w_gol_dir;
  logic        w_hit1;
  logic        w_hit2;

  assign w_bx     = {2'b00, x_bola_q};
  assign w_by     = {2'b00, y_bola_q};
  assign w_bx_fim = w_bx + c_tam;
  assign w_by_fim = w_by + c_tam;
  assign w_vel_h  = 11'(VELOCIDADE_BASE) + {1'b0, bonus_q};

  // Strict overlap of the ball square with a paddle rectangle on both axes.
  function automatic logic sobrepoe(input logic [9:0] xb, input logic [9:0] yb);
    logic [11:0] px;
    logic [11:0] py;
    px = {2'b00, xb};
    py = {2'b00, yb};
    return (w_bx < px + c_larg) && (w_bx_fim > px) &&
           (w_by < py + c_alt)  && (w_by_fim > py);
  endfunction

  assign w_hit1 = sobrepoe(bus.x_barra1, bus.y_barra1) && !dir_x_q;
  assign w_hit2 = sobrepoe(bus.x_barra2, bus.y_barra2) && dir_x_q;

  assign w_gol_dir = !dir_x_q && (w_bx <= c_lim_esq);
  assign w_gol_esq = dir_x_q && (w_bx_fim >= c_lim_dir);

  assign w_dir_y_nova = (!dir_y_q && (w_by <= c_lim_cima))      ? 1'b1 :
                        (dir_y_q  && (w_by_fim >= c_lim_baixo)) ? 1'b0 :
                        dir_y_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q   <= PARADA;
      x_bola_q   <= c_x_ini;
      y_bola_q   <= c_y_ini;
      dir_x_q    <= 1'b1;
      dir_y_q    <= 1'b1;
      em_jogo_q  <= 1'b0;
      gol_esq_q  <= 1'b0;
      gol_dir_q  <= 1'b0;
      cont_h_q   <= '0;
      cont_v_q   <= '0;
      cont_gol_q <= '0;
      bonus_q    <= '0;
    end else begin
      gol_esq_q <= 1'b0;
      gol_dir_q <= 1'b0;
      case (estado_q)
        PARADA: begin
          x_bola_q   <= c_x_ini;
          y_bola_q   <= c_y_ini;
          cont_h_q   <= '0;
          cont_v_q   <= '0;
          cont_gol_q <= '0;
          if (!bus.saque) begin
            estado_q  <= JOGO;
            em_jogo_q <= 1'b1;
          end
        end

        JOGO: begin
          if (cont_v_q >= c_limiar) begin
            cont_v_q <= '0;
            dir_y_q  <= w_dir_y_nova;
            y_bola_q <= w_dir_y_nova ? y_bola_q + 10'd1 : y_bola_q - 10'd1;
          end else begin
            cont_v_q <= cont_v_q + c_vel_base;
          end

          // Goal beats paddle contact; the direction test blocks double reflections.
          if (cont_h_q >= c_limiar) begin
            cont_h_q <= '0;
            if (w_gol_dir || w_gol_esq) begin
              gol_dir_q <= w_gol_dir;
              gol_esq_q <= w_gol_esq;
              dir_x_q   <= w_gol_esq;
              estado_q  <= GOL;
              em_jogo_q <= 1'b0;
              bonus_q   <= '0;
            end else if (w_hit1) begin
              dir_x_q  <= 1'b1;
              bonus_q  <= bus.vel_porradao1;
              x_bola_q <= x_bola_q + 10'd1;
            end else if (w_hit2) begin
              dir_x_q  <= 1'b0;
              bonus_q  <= bus.vel_porradao2;
              x_bola_q <= x_bola_q - 10'd1;
            end else begin
              x_bola_q <= dir_x_q ? x_bola_q + 10'd1 : x_bola_q - 10'd1;
            end
          end else begin
            cont_h_q <= cont_h_q + {21'd0, w_vel_h};
          end
        end

        GOL: begin
          cont_h_q <= '0;
          cont_v_q <= '0;
          if (cont_gol_q >= c_tempo_gol) begin
            x_bola_q   <= c_x_ini;
            y_bola_q   <= c_y_ini;
            cont_gol_q <= '0;
            estado_q   <= PARADA;
          end else begin
            cont_gol_q <= cont_gol_q + 32'd1;
          end
        end

        default: begin
          estado_q  <= PARADA;
          em_jogo_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x_bola  = x_bola_q;
  assign bus.y_bola  = y_bola_q;
  assign bus.dir_x   = dir_x_q;
  assign bus.dir_y   = dir_y_q;
  assign bus.em_jogo = em_jogo_q;
  assign bus.gol_esq = gol_esq_q;
  assign bus.gol_dir = gol_dir_q;

endmodule
`default_nettype wire

// File: doc/bola.md
# bola

Puck/ball engine for the two-paddle arena: consumes the position and smash-speed outputs of both paddle instances, moves the ball across the field, reflects it off the top/bottom walls and the paddles, and reports goals. It is the reading end of the paddle interface (`x_barra`, `y_barra`, `velocidadePorradao`) and drives the ball coordinates used by the VGA renderer and the score counter.

## Interface
- `X_INICIAL`, 318: serve/reset x of the ball's top-left corner.
- `Y_INICIAL`, 238: serve/reset y of the ball's top-left corner.
- `TAMANHO_BOLA`, 4: ball side, in pixels (square).
- `LARGURA_BARRA`, 20 / `ALTURA_BARRA`, 60: paddle rectangle, in pixels.
- `LIMITE_ESQ`, 0 / `LIMITE_DIR`, 640 / `LIMITE_CIMA`, 0 / `LIMITE_BAIXO`, 480: field limits.
- `VELOCIDADE_BASE`, 10: per-cycle accumulator increment.
- `LIMIAR`, 2500000: accumulator threshold for a one-pixel step.
- `TEMPO_GOL`, 50000000: cycles spent in GOL before re-centering.
- `clk` in 1: system clock. Single clock domain.
- `reset` in 1: asynchronous, active-low. 0 forces the reset state immediately.
- `x_barra1`, `y_barra1`, `vel_porradao1` in 10 each: left paddle top-left corner and smash speed.
- `x_barra2`, `y_barra2`, `vel_porradao2` in 10 each: right paddle top-left corner and smash speed.
- `saque` in 1: serve button, active-low level.
- `x_bola`, `y_bola` out 10 each: ball top-left corner.
- `dir_x` out 1: 1 = moving right. `dir_y` out 1: 1 = moving down.
- `em_jogo` out 1: high in state JOGO.
- `gol_esq` out 1: one-cycle pulse when the left player scores (ball reaches right limit).
- `gol_dir` out 1: one-cycle pulse when the right player scores (ball reaches left limit).

## Operation
- States:
  - PARADA: ball held at (`X_INICIAL`,`Y_INICIAL`), accumulators held at 0. `saque`==0 sampled on a clock edge → JOGO.
  - JOGO: ball moves.
  - GOL: position frozen, `contadorGol` counts. When `contadorGol` >= `TEMPO_GOL`: position ← initial, counter ← 0, → PARADA.
- Reset values:
  - State PARADA; `x_bola`=`X_INICIAL`, `y_bola`=`Y_INICIAL`.
  - `dir_x`=1, `dir_y`=1.
  - `em_jogo`=0, `gol_esq`=0, `gol_dir`=0.
  - `contadorH`=0, `contadorV`=0, `bonus`=0, `contadorGol`=0.
- Accumulators: 32-bit, JOGO only. Each cycle `contadorV` += `VELOCIDADE_BASE` and `contadorH` += `VELOCIDADE_BASE` + `bonus`. The horizontal speed sum is 11 bits, zero-extended.
- When a counter is >= `LIMIAR` on a cycle, that cycle performs the step and clears the counter to 0. The clear overrides the increment; there is no remainder carry.
- Vertical step, evaluated on the current `y_bola`:
  - If `dir_y`=0 and `y_bola` <= `LIMITE_CIMA`: `dir_y` ← 1.
  - If `dir_y`=1 and `y_bola`+`TAMANHO_BOLA` >= `LIMITE_BAIXO`: `dir_y` ← 0.
  - Then move one pixel in the resulting direction.
- Horizontal step, evaluated on current registers and current paddle inputs, in priority order:
  1. Goal:
     - `dir_x`=0 and `x_bola` <= `LIMITE_ESQ` → `gol_dir` pulse, next serve `dir_x`=0.
     - `dir_x`=1 and `x_bola`+`TAMANHO_BOLA` >= `LIMITE_DIR` → `gol_esq` pulse, next serve `dir_x`=1.
     - In both cases → GOL, no move, `bonus` ← 0.
  2. Paddle hit: the ball rectangle overlaps a paddle rectangle with strict overlap on both axes (`x_bola` < `x_barra`+`LARGURA_BARRA` and `x_bola`+`TAMANHO_BOLA` > `x_barra`, same form on y), and the ball is moving toward that paddle (paddle 1 needs `dir_x`=0, paddle 2 needs `dir_x`=1). Then `dir_x` is inverted, `bonus` ← that paddle's `vel_porradao`, and the ball moves one pixel in the new direction.
  3. Otherwise move one pixel in `dir_x`.
- A hit with `vel_porradao`=0 clears `bonus`. An overlap while moving away is ignored, so a paddle never reflects the ball twice.
- `dir_y` is preserved across GOL and serve.

## Timing
- Step period at constant speed v: ceil(`LIMIAR`/v)+1 cycles.
- `em_jogo` rises the cycle after `saque` is sampled low. The first steps come a full step period later.
- Goal pulse: registered, high exactly one cycle, asserted on the cycle following the step evaluation. `em_jogo` falls in the same cycle.
- Paddle inputs are sampled only on step cycles; changes between step cycles are invisible.
- `saque` is ignored outside PARADA; held low, it re-serves immediately on entry to PARADA.
- A `reset` low at any time, including mid-GOL, asynchronously restores all reset values. Operation resumes on the first edge after release.

## Test plan
- Common params: `LIMIAR`=100, `VELOCIDADE_BASE`=10, `TEMPO_GOL`=20, other params default; step period is 11 cycles.
- Idle: release reset, `saque`=1 for 500 cycles → `x_bola`=318, `y_bola`=238, `em_jogo`=0 throughout.
- Serve: `saque` low 1 cycle, paddles parked at y=400 → `em_jogo`=1; after the first step period x=319, y=239; steps continue every 11 cycles.
- Bottom wall: `Y_INICIAL`=474 → y sequence 474, 475, 476, 475, with `dir_y` 1→0 at the step from 476.
- Smash hit: paddle 2 at (330,220), `vel_porradao2`=30 → at the step where x=327, `dir_x`→0 and x→326; horizontal period becomes 4 cycles; vertical period stays 11.
- Goal: paddles parked out of the ball's path, ball runs right until x=636 → `gol_esq` high exactly 1 cycle, `em_jogo`=0, position frozen for 20 cycles, then (318,238), PARADA; next serve moves x to 319.
- Async reset: pull `reset` low mid-JOGO between clock edges → outputs equal reset values before the next edge; after release, `saque` is required to restart.
